// File: rtl/skewed_bank_buffer.sv
// skewed_bank_buffer: banked burst buffer with registered reads; SKEWED_BANK_BUFFER_SKEW_OUT_EN delays read lane i by i cycles
module skewed_bank_buffer #(
  parameter int NUM_BANKS = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_rdwr,
  input  logic [AW-1:0]               req_addr,
  input  logic [7:0]                  req_len,
  input  logic [NUM_BANKS-1:0]        req_mask,
  input  logic [NUM_BANKS*DATA_W-1:0] din,
  output logic                        din_ready,
  output logic [NUM_BANKS*DATA_W-1:0] rsp_data,
  output logic [NUM_BANKS-1:0]        rsp_lane_valid,
  output logic                        rsp_last,
  output logic                        busy
);
`ifdef SKEWED_BANK_BUFFER_SKEW_OUT_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state, state_nx;
  logic [AW-1:0] addr;
  logic [7:0] len, cnt;
  logic [NUM_BANKS-1:0] mask, pend;
  logic accept, last_beat, rd_en;
  assign req_ready = rst_n && state == IDLE;
  assign accept = req_valid && req_ready;
  assign last_beat = cnt == len;
  assign rd_en = state == READ;
  assign din_ready = state == WRITE;
  assign busy = state != IDLE || |pend;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = accept ? (req_rdwr ? WRITE : READ) : IDLE;
    else if (last_beat) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      len <= '0;
      cnt <= '0;
      mask <= '0;
      rsp_last <= 1'b0;
    end else begin
      state <= state_nx;
      rsp_last <= rd_en && last_beat;
      if (accept) begin
        addr <= req_addr;
        len <= req_len;
        mask <= req_mask;
        cnt <= '0;
      end else if (state != IDLE) begin
        addr <= addr + 1'b1;
        cnt <= last_beat ? '0 : cnt + 1'b1;
      end
    end
  end
  for (genvar g = 0; g < NUM_BANKS; g++) begin : lane
    localparam int L = SKEW ? g : 0;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] pd [L+1];
    logic [L:0] pv;
    always_ff @(posedge clk) begin
      if (state == WRITE && mask[g]) mem[addr] <= din[g*DATA_W +: DATA_W];
    end
    // stage 0 is the registered read; later stages only shift when valid so the output holds
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv <= '0;
        for (int j = 0; j <= L; j++) pd[j] <= '0;
      end else begin
        pv[0] <= rd_en;
        if (rd_en) pd[0] <= mem[addr];
        for (int j = 1; j <= L; j++) begin
          pv[j] <= pv[j-1];
          if (pv[j-1]) pd[j] <= pd[j-1];
        end
      end
    end
    assign rsp_data[g*DATA_W +: DATA_W] = pd[L];
    assign rsp_lane_valid[g] = pv[L];
    assign pend[g] = |pv;
  end
endmodule

// File: tb/tb_skewed_bank_buffer.sv
// tb_skewed_bank_buffer: scoreboard bench with a flat-array memory model and per-lane expected queues
module tb_skewed_bank_buffer;
  localparam int NB = 16, DW = 8, DEPTH = 64, AW = 6;
`ifdef SKEWED_BANK_BUFFER_SKEW_OUT_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, req_rdwr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [7:0] req_len = '0;
  logic [NB-1:0] req_mask = '0;
  logic [NB*DW-1:0] din = '0, rsp_data;
  logic din_ready, rsp_last, busy;
  logic [NB-1:0] rsp_lane_valid;
  skewed_bank_buffer #(.NUM_BANKS(NB), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_rdwr(req_rdwr),
    .req_addr(req_addr), .req_len(req_len), .req_mask(req_mask), .din(din), .din_ready(din_ready),
    .rsp_data(rsp_data), .rsp_lane_valid(rsp_lane_valid), .rsp_last(rsp_last), .busy(busy)
  );
  typedef struct {logic [DW-1:0] d; int t; bit last;} exp_t;
  exp_t q [NB][$];
  logic [DW-1:0] model [NB][DEPTH];
  logic [NB*DW-1:0] wq [$];
  int vectors = 0, miscompares = 0, cyc = 0, last_acc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [NB*DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  // monitor: pops one expected entry per valid lane and checks data, arrival cycle and last flag
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < NB; i++)
        if (rsp_lane_valid[i]) begin
          if (q[i].size() == 0) chk($sformatf("unexpected_lane%0d", i), rsp_lane_valid[i], 0);
          else begin
            e = q[i].pop_front();
            chk($sformatf("data_lane%0d", i), rsp_data[i*DW +: DW], e.d);
            chk($sformatf("time_lane%0d", i), cyc, e.t);
            if (i == 0) chk("rsp_last", rsp_last, e.last);
          end
        end
      if (rsp_last) chk("last_without_valid", rsp_lane_valid[0], 1);
      if (rsp_lane_valid != 0 || din_ready) chk("busy_active", busy, 1);
    end
  end
  task automatic burst(input bit wr, input int a, input int len, input logic [NB-1:0] m, input bit hold);
    int n = 0;
    int c;
    logic [NB*DW-1:0] w;
    req_valid = 1'b1; req_rdwr = wr; req_addr = a[AW-1:0]; req_len = len[7:0]; req_mask = m;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin chk("accept_timeout", req_ready, 1); req_valid = 1'b0; return; end
    c = cyc;
    last_acc = c;
    if (!wr)
      for (int k = 0; k <= len; k++)
        for (int i = 0; i < NB; i++)
          q[i].push_back('{model[i][(a + k) % DEPTH], c + 2 + k + SKEW * i, k == len});
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      chk("req_ready_in_burst", req_ready, 0);
      chk("din_ready", din_ready, wr);
      if (wr) begin
        w = wq.size() != 0 ? wq.pop_front() : rnd();
        din = w;
        for (int i = 0; i < NB; i++) if (m[i]) model[i][(a + k) % DEPTH] = w[i*DW +: DW];
      end
      @(negedge clk);
    end
  endtask
  task automatic drain();
    int n = 0;
    int pending;
    do begin
      pending = 0;
      for (int i = 0; i < NB; i++) pending += q[i].size();
      if (busy || pending != 0) begin @(negedge clk); n++; end
    end while ((busy || pending != 0) && n < 500);
    chk("drain_busy", busy, 0);
    chk("drain_pending", pending, 0);
  endtask
  initial begin
    int c1, n;
    logic [NB*DW-1:0] w;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_din_ready", din_ready, 0);
    chk("rst_lane_valid", rsp_lane_valid, 0);
    chk("rst_last", rsp_last, 0);
    chk("rst_data", rsp_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", req_ready, 1);
    burst(1, 0, 63, '1, 0);
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < NB; i++) w[i*DW +: DW] = 8'(16 * b + i);
      wq.push_back(w);
    end
    burst(1, 0, 3, '1, 0);
    burst(0, 0, 3, 16'($urandom), 0);
    drain();
    burst(1, 62, 3, '1, 0);
    burst(0, 62, 3, '0, 0);
    wq.push_back('1);
    burst(1, 5, 0, '1, 0);
    wq.push_back('0);
    burst(1, 5, 0, 16'h0001, 0);
    burst(0, 5, 0, '1, 0);
    drain();
    burst(0, 3, 0, '1, 0);
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk("busy_fall", n, SKEW ? NB : 1);
    drain();
    req_valid = 1'b1; req_rdwr = 1'b1; req_addr = 6'd10; req_len = 8'd7; req_mask = '1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      w = rnd();
      din = w;
      for (int i = 0; i < NB; i++) model[i][10 + k] = w[i*DW +: DW];
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_din_ready", din_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", rsp_lane_valid, 0);
    chk("mid_rst_last", rsp_last, 0);
    chk("mid_rst_data", rsp_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_req_ready", req_ready, 1);
    burst(0, 10, 7, '0, 0);
    burst(1, 20, 2, 16'($urandom), 1);
    c1 = last_acc;
    chk("b2b_ready", req_ready, 1);
    burst(0, 20, 2, '1, 0);
    chk("b2b_cycle", last_acc, c1 + 4);
    for (int r = 0; r < 24; r++)
      burst($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 12), 16'($urandom),
            r < 23 ? $urandom_range(0, 1) : 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
